// File: rtl/vga_rx_pkg.sv
// vga_rx_pkg: shared types and constants for the VGA stream receiver.
//   state_e  - raster lock state (SEARCH, ACQUIRE, LOCKED)
//   pixel_t  - one RGB pixel as carried on the write port
//   sat_inc  - counter increment that sticks at the all-ones value
package vga_rx_pkg;

    localparam int unsigned CNT_W           = 11;
    localparam int unsigned RGB_W           = 10;
    localparam int unsigned DEF_H_ACT       = 640;
    localparam int unsigned DEF_V_ACT       = 480;
    localparam int unsigned DEF_LOCK_FRAMES = 2;
    localparam int unsigned DEF_ADDR_W      = 22;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    typedef struct packed {
        logic [RGB_W-1:0] red;
        logic [RGB_W-1:0] green;
        logic [RGB_W-1:0] blue;
    } pixel_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: two-stage sampler for one sync/blank line with edge pulses.
//   clk, rst : pixel clock, asynchronous active-high reset
//   d        : raw input level
//   s1       : stage-1 registered level
//   fall_c   : stage-2 high and stage-1 low (combinational)
//   rise_c   : stage-2 low and stage-1 high (combinational)
// RST_VAL is the idle level, so leaving reset never produces an edge.
module vga_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s1,
    output logic fall_c,
    output logic rise_c
);

    logic s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign fall_c = s2 & ~s1;
    assign rise_c = ~s2 & s1;

endmodule

// File: rtl/vga_stream_rx.sv
// vga_stream_rx: VGA pixel stream receiver feeding the frame-buffer write port.
//   iCLK, iRST              : pixel clock, asynchronous active-high reset
//   iHS, iVS                : active-low syncs; falling edges start line / frame
//   iBLANK, iRed/iGreen/iBlue : 1 = active video, with its pixel data
//   oRed/oGreen/oBlue, oCurrent_X/Y, oAddress, oWrite : write port, 2-cycle latency
//   oFrame_Start            : pulse per VS falling edge
//   oLocked                 : raster locked onto H_ACT x V_ACT
//   oH_Total, oV_Total      : measured clocks/line and lines/frame
//   oErr                    : pulse on a bad line or bad frame
module vga_stream_rx
    import vga_rx_pkg::*;
#(
    parameter int unsigned H_ACT       = DEF_H_ACT,
    parameter int unsigned V_ACT       = DEF_V_ACT,
    parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iHS,
    input  logic              iVS,
    input  logic              iBLANK,
    input  logic [RGB_W-1:0]  iRed,
    input  logic [RGB_W-1:0]  iGreen,
    input  logic [RGB_W-1:0]  iBlue,
    output logic [RGB_W-1:0]  oRed,
    output logic [RGB_W-1:0]  oGreen,
    output logic [RGB_W-1:0]  oBlue,
    output logic [CNT_W-1:0]  oCurrent_X,
    output logic [CNT_W-1:0]  oCurrent_Y,
    output logic [ADDR_W-1:0] oAddress,
    output logic              oWrite,
    output logic              oFrame_Start,
    output logic              oLocked,
    output logic [CNT_W-1:0]  oH_Total,
    output logic [CNT_W-1:0]  oV_Total,
    output logic              oErr
);

    localparam int unsigned       GOOD_W   = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0]  H_LIM    = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0]  V_LIM    = CNT_W'(V_ACT);
    localparam logic [GOOD_W-1:0] GOOD_LIM = GOOD_W'(LOCK_FRAMES);

    state_e            state, state_nxt;
    logic [GOOD_W-1:0] good_cnt, good_nxt;
    logic [CNT_W-1:0]  h_cnt, line_cnt, x_cnt, y_cnt;
    logic              bad;
    pixel_t            pix_s1;

    logic blank_s1, hs_lvl, vs_lvl;
    logic line_start_c, frame_start_c, eol_c;
    logic hs_rise, vs_rise, blank_rise;
    logic unused_edges;

    logic [CNT_W-1:0]  x_cur_c, y_cur_c, y_line_c, line_inc_c;
    logic              eol_good_c, eol_bad_c, bad_line_c, frame_good_c;
    logic              frame_err_c, write_c;
    logic [ADDR_W-1:0] addr_c;

    vga_sync_edge #(.RST_VAL(1'b1)) u_hs (
        .clk(iCLK), .rst(iRST), .d(iHS),
        .s1(hs_lvl), .fall_c(line_start_c), .rise_c(hs_rise)
    );

    vga_sync_edge #(.RST_VAL(1'b1)) u_vs (
        .clk(iCLK), .rst(iRST), .d(iVS),
        .s1(vs_lvl), .fall_c(frame_start_c), .rise_c(vs_rise)
    );

    vga_sync_edge #(.RST_VAL(1'b0)) u_blank (
        .clk(iCLK), .rst(iRST), .d(iBLANK),
        .s1(blank_s1), .fall_c(eol_c), .rise_c(blank_rise)
    );

    // Sync levels and rising edges carry no information this receiver needs.
    assign unused_edges = ^{hs_lvl, vs_lvl, hs_rise, vs_rise, blank_rise};

    // Coordinate of the stage-1 pixel and end-of-line / end-of-frame verdicts.
    // The line verdict is folded in before the frame verdict so a BLANK fall
    // coinciding with a VS fall still counts toward the frame it closes.
    always_comb begin
        x_cur_c      = line_start_c ? '0 : x_cnt;
        y_cur_c      = frame_start_c ? '0 : y_cnt;
        eol_good_c   = eol_c && (x_cnt == H_LIM);
        eol_bad_c    = eol_c && (x_cnt != '0) && (x_cnt != H_LIM);
        y_line_c     = eol_good_c ? sat_inc(y_cnt) : y_cnt;
        bad_line_c   = bad | eol_bad_c;
        frame_good_c = !bad_line_c && (y_line_c == V_LIM);
        line_inc_c   = line_start_c ? sat_inc(line_cnt) : line_cnt;
        write_c      = (state_nxt == LOCKED) && blank_s1 &&
                       (x_cur_c < H_LIM) && (y_cur_c < V_LIM);
        addr_c       = ADDR_W'(y_cur_c) * ADDR_W'(H_ACT) + ADDR_W'(x_cur_c);
    end

    // Lock state register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= SEARCH;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Lock next-state; only a frame start moves it. Frame errors are not
    // reported out of SEARCH since that frame was never tracked from its start.
    always_comb begin
        state_nxt   = state;
        good_nxt    = good_cnt;
        frame_err_c = 1'b0;
        if (frame_start_c) begin
            case (state)
                SEARCH: begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
                ACQUIRE: begin
                    if (frame_good_c) begin
                        good_nxt = good_cnt + GOOD_W'(1);
                        if (good_nxt >= GOOD_LIM) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt    = '0;
                        frame_err_c = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!frame_good_c) begin
                        state_nxt   = SEARCH;
                        frame_err_c = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // Pixel stage, raster counters and registered outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            pix_s1       <= '0;
            h_cnt        <= '0;
            line_cnt     <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            bad          <= 1'b0;
            oRed         <= '0;
            oGreen       <= '0;
            oBlue        <= '0;
            oCurrent_X   <= '0;
            oCurrent_Y   <= '0;
            oAddress     <= '0;
            oWrite       <= 1'b0;
            oFrame_Start <= 1'b0;
            oLocked      <= 1'b0;
            oH_Total     <= '0;
            oV_Total     <= '0;
            oErr         <= 1'b0;
        end else begin
            pix_s1   <= {iRed, iGreen, iBlue};
            h_cnt    <= line_start_c ? '0 : sat_inc(h_cnt);
            line_cnt <= frame_start_c ? '0 : line_inc_c;
            x_cnt    <= blank_s1 ? sat_inc(x_cur_c) : x_cur_c;
            y_cnt    <= frame_start_c ? '0 : y_line_c;
            bad      <= frame_start_c ? 1'b0 : bad_line_c;

            if (line_start_c) begin
                oH_Total <= sat_inc(h_cnt);
            end
            if (frame_start_c) begin
                oV_Total <= line_inc_c;
            end

            oWrite       <= write_c;
            oFrame_Start <= frame_start_c;
            oErr         <= eol_bad_c | frame_err_c;
            oLocked      <= (state_nxt == LOCKED);

            // Port payload only moves with a write, so it never holds an
            // out-of-range coordinate.
            if (write_c) begin
                oRed       <= pix_s1.red;
                oGreen     <= pix_s1.green;
                oBlue      <= pix_s1.blue;
                oCurrent_X <= x_cur_c;
                oCurrent_Y <= y_cur_c;
                oAddress   <= addr_c;
            end
        end
    end

endmodule

// File: tb/tb_vga_stream_rx.sv
// Directed bench for vga_stream_rx on a reduced 12x6 raster (8x4 active).
module tb_vga_stream_rx;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int LT = 12;
    localparam int FT = 6;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        hs    = 1'b1;
    logic        vs    = 1'b1;
    logic        blank = 1'b0;
    logic [9:0]  ri = '0, gi = '0, bi = '0;
    logic [9:0]  ro, go, bo;
    logic [10:0] cx, cy, htot, vtot;
    logic [21:0] addr;
    logic        wr, fs, lk, er;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    // stimulus bookkeeping
    logic [29:0] hist [4];
    int vs_cyc, first_act_cyc, eol_cyc;

    // monitor bookkeeping
    int fs_cnt = 0, err_cnt = 0, wr_total = 0, fr_wr = 0;
    int fr_first_addr = -1, fr_last_addr = -1, fr_first_cyc = 0;
    int fs_cyc = 0, err_cyc = 0;
    int fr_seq_bad = 0, data_bad = 0, addr_bad = 0, range_bad = 0;
    int wr0, e0;

    vga_stream_rx #(
        .H_ACT(H), .V_ACT(V), .LOCK_FRAMES(2), .ADDR_W(22)
    ) dut (
        .iCLK(clk), .iRST(rst),
        .iHS(hs), .iVS(vs), .iBLANK(blank),
        .iRed(ri), .iGreen(gi), .iBlue(bi),
        .oRed(ro), .oGreen(go), .oBlue(bo),
        .oCurrent_X(cx), .oCurrent_Y(cy), .oAddress(addr),
        .oWrite(wr), .oFrame_Start(fs), .oLocked(lk),
        .oH_Total(htot), .oV_Total(vtot), .oErr(er)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fs) begin
            fs_cnt++;
            fs_cyc     = cyc;
            fr_wr      = 0;
            fr_seq_bad = 0;
        end
        if (er) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (wr) begin
            if (fr_wr == 0) begin
                fr_first_addr = int'(addr);
                fr_first_cyc  = cyc;
            end
            fr_last_addr = int'(addr);
            if (int'(cx) != fr_wr % H || int'(cy) != fr_wr / H) fr_seq_bad++;
            if ({ro, go, bo} !== hist[(cyc + 2) % 4]) data_bad++;
            if (int'(addr) != int'(cy) * H + int'(cx)) addr_bad++;
            if (int'(cx) >= H || int'(cy) >= V) range_bad++;
            fr_wr++;
            wr_total++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One 12x6 frame: HS low h=0..1, VS low on line 0, active lines 1..4.
    // Normal active span is h=3..10; short line ends at h=9; long line is h=1..11.
    // rst_line >= 0 pulses reset at h=5..7 of that line.
    task automatic drive_frame(input int short_idx, input int long_idx, input int rst_line);
        int lo, hi, act_idx;
        logic act;
        for (int ln = 0; ln < FT; ln++) begin
            for (int h = 0; h < LT; h++) begin
                @(negedge clk);
                act_idx = ln - 1;
                lo = 3;
                hi = 10;
                if (act_idx == short_idx) hi = 9;
                if (act_idx == long_idx) begin
                    lo = 1;
                    hi = 11;
                end
                act   = (ln >= 1) && (ln <= V) && (h >= lo) && (h <= hi);
                rst   = (ln == rst_line) && (h >= 5) && (h <= 7);
                hs    = (h >= 2);
                vs    = (ln != 0);
                blank = act;
                ri    = act ? 10'(h - lo) : 10'(0);
                gi    = act ? 10'(act_idx) : 10'(0);
                bi    = 10'(cyc);
                hist[cyc % 4] = {ri, gi, bi};
                if (ln == 0 && h == 0) vs_cyc = cyc;
                if (act_idx == 0 && h == lo) first_act_cyc = cyc;
                if (ln >= 1 && ln <= V && act_idx == short_idx && h == hi + 1) eol_cyc = cyc;
                if (ln == rst_line && h == 7)
                    chk("outputs_zero_in_midline_reset",
                        int'(|{ro, go, bo, cx, cy, addr, wr, fs, lk, htot, vtot, er}), 0);
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        chk("outputs_zero_in_reset",
            int'(|{ro, go, bo, cx, cy, addr, wr, fs, lk, htot, vtot, er}), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("no_frame_start_after_reset", fs_cnt, 0);
        chk("no_err_after_reset", err_cnt, 0);

        // Acquire: two good frames, lock at the third frame start.
        drive_frame(-1, -1, -1);
        chk("frame_start_count_f1", fs_cnt, 1);
        chk("frame_start_latency", fs_cyc - vs_cyc, 2);
        drive_frame(-1, -1, -1);
        chk("no_write_before_lock", wr_total, 0);
        chk("unlocked_before_lock", int'(lk), 0);
        drive_frame(-1, -1, -1);
        chk("locked_f3", int'(lk), 1);
        chk("h_total", int'(htot), LT);
        chk("v_total_hs_vs_coincident", int'(vtot), FT);
        chk("writes_f3", fr_wr, H * V);
        chk("first_addr_f3", fr_first_addr, 0);
        chk("last_addr_f3", fr_last_addr, H * V - 1);
        chk("write_latency_f3", fr_first_cyc - first_act_cyc, 2);
        chk("write_sequence_f3", fr_seq_bad, 0);
        chk("no_err_clean_lock", err_cnt, 0);

        // Reset in the middle of an active line while locked.
        drive_frame(-1, -1, 2);
        chk("no_false_frame_start_after_midreset", fs_cnt, 4);
        chk("unlocked_after_midreset", int'(lk), 0);
        wr0 = wr_total;
        drive_frame(-1, -1, -1);
        drive_frame(-1, -1, -1);
        chk("no_write_during_relock", wr_total - wr0, 0);
        chk("unlocked_two_frames_after_reset", int'(lk), 0);
        drive_frame(-1, -1, -1);
        chk("relocked_after_reset", int'(lk), 1);
        chk("writes_after_reset_relock", fr_wr, H * V);
        chk("write_sequence_after_relock", fr_seq_bad, 0);
        chk("write_latency_after_relock", fr_first_cyc - first_act_cyc, 2);
        chk("h_total_after_reset", int'(htot), LT);
        chk("v_total_after_reset", int'(vtot), FT);

        // Short line (H-1 pixels) at active line 2 while locked.
        e0 = err_cnt;
        drive_frame(2, -1, -1);
        chk("short_line_err_once", err_cnt - e0, 1);
        chk("short_line_err_latency", err_cyc - eol_cyc, 2);
        chk("short_line_frame_writes", fr_wr, 3 * H + (H - 1));
        chk("still_locked_until_frame_start", int'(lk), 1);

        // Bad frame drops lock, then SEARCH, ACQUIRE, two good frames.
        e0  = err_cnt;
        wr0 = wr_total;
        drive_frame(-1, -1, -1);
        chk("lock_dropped_after_bad_frame", int'(lk), 0);
        drive_frame(-1, -1, -1);
        drive_frame(-1, -1, -1);
        chk("bad_frame_err_once", err_cnt - e0, 1);
        chk("no_write_while_reacquiring", wr_total - wr0, 0);
        chk("unlocked_before_relock", int'(lk), 0);

        // Long line (H+3 pixels) at active line 1 while locked.
        e0 = err_cnt;
        drive_frame(-1, 1, -1);
        chk("relocked_after_two_good", int'(lk), 1);
        chk("long_line_frame_writes", fr_wr, H * V);
        chk("long_line_err_once", err_cnt - e0, 1);
        drive_frame(-1, -1, -1);
        chk("long_line_frame_drops_lock", int'(lk), 0);
        chk("long_line_frame_err_total", err_cnt - e0, 2);

        chk("write_data_matches_input", data_bad, 0);
        chk("write_address_formula", addr_bad, 0);
        chk("write_coord_range", range_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
